// File: rtl/counter_pulse_ctrl_if.sv
// Purpose: control/status bundle between board logic, the cascaded counter and counter_pulse_ctrl.
// Latency: none (wires only).
// Backpressure: none; start is a level request sampled by the sequencer only when idle.
//
// Signals: start/abort request and cancel, div pulse spacing, len pulse count,
// q counter read-back, cin increment pulse, busy/done/err/wrapped status.
interface counter_pulse_ctrl_if #(
    parameter int DIV_W = 16
);
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] div;
    logic [7:0]       len;
    logic [7:0]       q;
    logic             cin;
    logic             busy;
    logic             done;
    logic             err;
    logic             wrapped;

    // master: board control plus counter read-back; slave: the sequencer
    modport master (
        output start, abort, div, len, q,
        input  cin, busy, done, err, wrapped
    );

    modport slave (
        input  start, abort, div, len, q,
        output cin, busy, done, err, wrapped
    );
endinterface

// File: rtl/counter_pulse_ctrl.sv
// Purpose: issues len cin pulses spaced div+1 clocks apart, then verifies q advanced by len (mod 256).
// Latency: start-to-done is 3 + (len-1)(div+1) + SETTLE cycles for len>0, SETTLE+2 for len=0.
// Backpressure: start is ignored (not queued) while busy; abort cancels any active sequence at once.
//
// Ports: clk, rst_n (async, active low), bus (slave modport of counter_pulse_ctrl_if).
// Outputs: cin registered pulse, busy = LOAD..CHECK, done = CHECK cycle, err/wrapped sticky until next start.
module counter_pulse_ctrl #(
    parameter int DIV_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    counter_pulse_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [2:0]       state, state_n;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] ps, ps_n;
    logic [7:0]       len_l;
    logic [7:0]       pc, pc_n;
    logic [3:0]       sc, sc_n;
    logic [7:0]       base;
    logic [7:0]       q_prev;
    logic [7:0]       expect_q;
    logic             cin_r;
    logic             err_r;
    logic             wrapped_r;
    logic             accept;
    logic             active;

    assign accept   = (state == S_IDLE) && bus.start && !bus.abort;
    assign active   = (state == S_RUN) || (state == S_SETTLE);
    // 8-bit add, carry dropped: expected value wraps exactly like the counter
    assign expect_q = base + len_l;

    always_comb begin
        state_n = state;
        ps_n    = ps;
        pc_n    = pc;
        sc_n    = sc;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                ps_n    = '0;
                pc_n    = len_l;
                sc_n    = '0;
                state_n = (len_l == 8'd0) ? S_SETTLE : S_RUN;
            end
            S_RUN: begin
                if (ps == '0) begin
                    pc_n = pc - 8'd1;
                    ps_n = div_l;
                    // the pulse that empties pc is this cycle's pulse
                    if (pc == 8'd1) begin
                        state_n = S_SETTLE;
                        sc_n    = '0;
                    end
                end else begin
                    ps_n = ps - DIV_W'(1);
                end
            end
            S_SETTLE: begin
                if (sc == SETTLE_LAST) begin
                    state_n = S_CHECK;
                end else begin
                    sc_n = sc + 4'd1;
                end
            end
            S_CHECK: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (bus.abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_l     <= '0;
            ps        <= '0;
            len_l     <= '0;
            pc        <= '0;
            sc        <= '0;
            base      <= '0;
            q_prev    <= '0;
            cin_r     <= 1'b0;
            err_r     <= 1'b0;
            wrapped_r <= 1'b0;
        end else begin
            state  <= state_n;
            ps     <= ps_n;
            pc     <= pc_n;
            sc     <= sc_n;
            q_prev <= bus.q;
            // cin is registered from next-state values so it is high during
            // exactly those RUN cycles in which the prescaler reads zero
            cin_r  <= (state_n == S_RUN) && (ps_n == '0);

            if (accept) begin
                div_l     <= bus.div;
                len_l     <= bus.len;
                err_r     <= 1'b0;
                wrapped_r <= 1'b0;
            end
            if (state == S_LOAD) begin
                base <= bus.q;
            end
            // an abort leaves err and wrapped untouched
            if ((state == S_CHECK) && !bus.abort) begin
                err_r <= (bus.q != expect_q);
            end
            if (active && !bus.abort && (q_prev == 8'hFF) && (bus.q == 8'h00)) begin
                wrapped_r <= 1'b1;
            end
        end
    end

    assign bus.cin     = cin_r;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_CHECK) && !bus.abort;
    assign bus.err     = err_r;
    assign bus.wrapped = wrapped_r;
endmodule

// File: doc/counter_pulse_ctrl.md
# counter_pulse_ctrl

Sequencer for the 8-bit cascaded counter (two 4-bit stages, `cin` increment input, `q` count output). On a start request it issues a programmed number of single-cycle `cin` pulses at a programmed spacing. It then waits for the counter to settle and checks that `q` advanced by exactly that amount, modulo 256. It reports completion, a mismatch error and a wrap-through-zero flag. It sits between the board-level control logic and the counter datapath, and is the only driver of the counter's `cin`.

## Interface
- `DIV_W`, default 16: width of the pulse-spacing input `div`.
- `SETTLE`, default 2: cycles waited after the last pulse before `q` is compared. Legal range 1..15.
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE; ignored while busy.
- `abort`  in  1  cancels the sequence. Takes priority over every other event.
- `div`  in  DIV_W  pulse spacing. Consecutive `cin` pulses are `div`+1 clocks apart. Latched on start.
- `len`  in  8  number of `cin` pulses to issue, 0..255. Latched on start.
- `q`  in  8  counter value read back from the counter.
- `cin`  out  1  registered increment pulse to the counter.
- `busy`  out  1  high from LOAD through CHECK inclusive.
- `done`  out  1  one-cycle pulse, asserted in CHECK.
- `err`  out  1  result of the compare. Sticky until the next accepted start.
- `wrapped`  out  1  high if `q` went from 8'hFF to 8'h00 during RUN or SETTLE. Sticky until the next accepted start.

## Operation
- Reset values: state = IDLE; `cin`, `busy`, `done`, `err` and `wrapped` all 0; internal counters 0.
- FSM states: IDLE, LOAD, RUN, SETTLE, CHECK.
- **IDLE**
  - If `start`=1 and `abort`=0: go to LOAD.
  - On that transition, latch `div` and `len`, and clear `err` and `wrapped`.
- **LOAD**
  - Capture `base` = `q`.
  - Load pulse count `pc` = `len` and prescaler `ps` = 0.
  - If `len`=0, go to SETTLE; otherwise go to RUN.
- **RUN**
  - When `ps`=0: assert `cin` for one cycle, decrement `pc`, reload `ps` = `div`.
  - Otherwise: decrement `ps` and keep `cin` low.
  - The cycle that issues the pulse bringing `pc` to 0 also transitions to SETTLE.
- **SETTLE**
  - Count `SETTLE` cycles with `cin` held 0, then go to CHECK.
- **CHECK**
  - `done`=1.
  - `err` = (`q` != (`base` + `len`) mod 256).
  - Go to IDLE.
- **Expected-value arithmetic:** 8-bit add, carry discarded. Example: `base`=8'hFA, `len`=10 gives expected 8'h04.
- **Wrap detect:** register `q` every cycle. Set `wrapped` when the previous `q` = 8'hFF and the current `q` = 8'h00 while state is RUN or SETTLE.
- **Abort**
  - From any non-IDLE state: the next state is IDLE.
  - `cin` is forced to 0 from the next cycle.
  - No `done` pulse is generated. `err` and `wrapped` keep their current values.
  - An abort in the same cycle as a start in IDLE suppresses the start.
- **Start while busy:** ignored and not queued.
- **`div`/`len` changes while busy:** no effect, because both values are latched.

## Timing
- Cycle 0: IDLE, `start`=1 sampled.
- Cycle 1: LOAD, `busy`=1.
- Cycle 2: first RUN cycle. `cin`=1 in this cycle when `len`>0.
- Pulse k (k = 1..`len`) is high in cycle 2 + (k-1)(`div`+1).
- The last pulse is in cycle L = 2 + (`len`-1)(`div`+1). SETTLE occupies cycles L+1 .. L+`SETTLE`. CHECK is cycle L+`SETTLE`+1.
- Total start-to-done latency for `len`>0: 3 + (`len`-1)(`div`+1) + `SETTLE` cycles.
- For `len`=0: SETTLE occupies cycles 2 .. `SETTLE`+1, and CHECK is cycle `SETTLE`+2.
- After CHECK the block returns to IDLE. `busy` falls in the cycle after CHECK, and a new start is accepted in that cycle.
- `div`=0 produces back-to-back `cin` pulses, one every clock.
- The counter is assumed to update `q` one clock after sampling `cin`. `SETTLE`≥1 covers this; the default of 2 leaves margin.

## Test plan
- **Basic run:** reset, `q`=0, `div`=4, `len`=5. Expect 5 `cin` pulses 5 clocks apart starting in cycle 2; `done` in cycle 25; `err`=0; `wrapped`=0; final `q`=5.
- **Wrap through zero:** preload the counter to 8'hFA, `div`=0, `len`=10. Expect 10 consecutive `cin` pulses, `q`=8'h04, `wrapped`=1, `err`=0.
- **Zero length:** `len`=0. Expect no `cin` pulses; `done` in cycle 4; `err`=0; `busy` high for cycles 1..4.
- **Mismatch:** model a counter that drops the 3rd pulse, `len`=6. Expect `done`=1 and `err`=1. `err` stays 1 until the next start, then clears.
- **Abort:** assert `abort` in the cycle of the 2nd pulse (`div`=3, `len`=8). Expect no `cin` from the next cycle, return to IDLE, no `done`, and `busy` low one cycle after the abort.
- **Reset mid-run:** drop `rst_n` during RUN. Expect all outputs to go to 0 immediately (asynchronously), and a new start afterwards to behave like the basic run.
